// File: rtl/led_pwm_fader.sv
// PWM LED driver that ramps its duty linearly towards the requested on/off level.
// Built from a free-running PWM counter, a free-running step timer and a 4-state ramp FSM.
module led_pwm_fader #(
    parameter int PWM_BITS        = 8,
    parameter int MAX_DUTY        = 255,
    parameter int STEP_DIV        = 49020,
    parameter bit LED_ACTIVE_HIGH = 1'b1
) (
    input  logic                sys_clk,
    input  logic                sys_rst,
    input  logic                led_req,
    input  logic                fade_en,
    output logic                led_out,
    output logic [PWM_BITS-1:0] duty,
    output logic                busy
);

    localparam int STEP_W = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
    localparam logic [PWM_BITS-1:0] DUTY_MAX  = PWM_BITS'(MAX_DUTY);
    localparam logic [PWM_BITS-1:0] DUTY_PEN  = PWM_BITS'(MAX_DUTY - 1);
    localparam logic [PWM_BITS-1:0] DUTY_ONE  = PWM_BITS'(1);
    localparam logic [STEP_W-1:0]   STEP_LAST = STEP_W'(STEP_DIV - 1);

    typedef enum logic [1:0] {
        OFF       = 2'd0,
        RAMP_UP   = 2'd1,
        ON        = 2'd2,
        RAMP_DOWN = 2'd3
    } state_t;

    state_t              state;
    logic [PWM_BITS-1:0] pwm_cnt;
    logic [STEP_W-1:0]   step_cnt;
    logic                step_tick;
    logic                led_on;

    assign step_tick = (step_cnt == STEP_LAST);

    // All-ones duty is forced fully on; otherwise the compare would leave one dark clock per period.
    assign led_on = (duty == '1) || (pwm_cnt < duty);

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            pwm_cnt  <= '0;
            step_cnt <= '0;
        end else begin
            pwm_cnt  <= pwm_cnt + 1'b1;
            step_cnt <= step_tick ? '0 : step_cnt + 1'b1;
        end
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            led_out <= ~LED_ACTIVE_HIGH;
        end else begin
            led_out <= LED_ACTIVE_HIGH ? led_on : ~led_on;
        end
    end

    // Direction changes take priority over a coincident step so duty never jumps on reversal.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state <= OFF;
            duty  <= '0;
            busy  <= 1'b0;
        end else if (!fade_en) begin
            state <= led_req ? ON : OFF;
            duty  <= led_req ? DUTY_MAX : '0;
            busy  <= 1'b0;
        end else begin
            case (state)
                OFF: begin
                    duty <= '0;
                    if (led_req) begin
                        state <= RAMP_UP;
                        busy  <= 1'b1;
                    end
                end
                RAMP_UP: begin
                    if (!led_req) begin
                        state <= RAMP_DOWN;
                        busy  <= 1'b1;
                    end else if (duty >= DUTY_MAX) begin
                        state <= ON;
                        duty  <= DUTY_MAX;
                        busy  <= 1'b0;
                    end else if (step_tick) begin
                        duty <= duty + 1'b1;
                        if (duty == DUTY_PEN) begin
                            state <= ON;
                            busy  <= 1'b0;
                        end
                    end
                end
                ON: begin
                    duty <= DUTY_MAX;
                    if (!led_req) begin
                        state <= RAMP_DOWN;
                        busy  <= 1'b1;
                    end
                end
                RAMP_DOWN: begin
                    if (led_req) begin
                        state <= RAMP_UP;
                        busy  <= 1'b1;
                    end else if (duty == '0) begin
                        state <= OFF;
                        busy  <= 1'b0;
                    end else if (step_tick) begin
                        duty <= duty - 1'b1;
                        if (duty == DUTY_ONE) begin
                            state <= OFF;
                            busy  <= 1'b0;
                        end
                    end
                end
                default: begin
                    state <= OFF;
                    duty  <= '0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_led_pwm_fader.sv
// Directed bench for led_pwm_fader with PWM_BITS=4, MAX_DUTY=15, STEP_DIV=4; an active-high and
// an active-low instance share all inputs.
module tb_led_pwm_fader;

    logic       sys_clk = 1'b0;
    logic       sys_rst = 1'b0;
    logic       led_req = 1'b0;
    logic       fade_en = 1'b1;
    logic       led_out;
    logic [3:0] duty;
    logic       busy;
    logic       led_out_n;
    logic [3:0] duty_n;
    logic       busy_n;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 sys_clk = ~sys_clk;

    led_pwm_fader #(.PWM_BITS(4), .MAX_DUTY(15), .STEP_DIV(4), .LED_ACTIVE_HIGH(1'b1)) dut (
        .sys_clk(sys_clk), .sys_rst(sys_rst), .led_req(led_req), .fade_en(fade_en),
        .led_out(led_out), .duty(duty), .busy(busy)
    );

    led_pwm_fader #(.PWM_BITS(4), .MAX_DUTY(15), .STEP_DIV(4), .LED_ACTIVE_HIGH(1'b0)) dut_n (
        .sys_clk(sys_clk), .sys_rst(sys_rst), .led_req(led_req), .fade_en(fade_en),
        .led_out(led_out_n), .duty(duty_n), .busy(busy_n)
    );

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic do_reset();
        led_req = 1'b0;
        fade_en = 1'b1;
        sys_rst = 1'b1;
        tick();
        tick();
        sys_rst = 1'b0;
    endtask

    task automatic test_reset();
        #2 sys_rst = 1'b1;
        #1;
        n_checks++;
        if (duty !== 4'd0 || busy !== 1'b0 || led_out !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_async: duty=%0d busy=%b led_out=%b, expected 0/0/0", duty, busy, led_out);
        end
        n_checks++;
        if (duty_n !== 4'd0 || busy_n !== 1'b0 || led_out_n !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_async_n: duty=%0d busy=%b led_out=%b, expected 0/0/1", duty_n, busy_n, led_out_n);
        end
        tick();
        tick();
        sys_rst = 1'b0;
        tick();
        n_checks++;
        if (duty !== 4'd0 || busy !== 1'b0 || led_out !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_idle: duty=%0d busy=%b led_out=%b, expected 0/0/0", duty, busy, led_out);
        end
    endtask

    task automatic test_ramp_up();
        int cyc;
        int ones;
        led_req = 1'b1;
        tick();
        cyc = 1;
        n_checks++;
        if (busy !== 1'b1 || duty !== 4'd0) begin
            n_fail++;
            $display("FAIL ramp_up_entry: busy=%b duty=%0d, expected 1/0", busy, duty);
        end
        for (int i = 0; i < 8 && duty !== 4'd1; i++) begin
            tick();
            cyc++;
        end
        n_checks++;
        if (duty !== 4'd1) begin
            n_fail++;
            $display("FAIL ramp_up_first_step: duty=%0d, expected 1", duty);
        end
        for (int k = 2; k <= 15; k++) begin
            repeat (4) tick();
            cyc += 4;
            n_checks++;
            if (duty !== 4'(k) || busy !== (k < 15)) begin
                n_fail++;
                $display("FAIL ramp_up_step: duty=%0d busy=%b, expected %0d/%b", duty, busy, k, (k < 15));
            end
        end
        n_checks++;
        if (cyc > 62) begin
            n_fail++;
            $display("FAIL ramp_up_time: took %0d clks, expected <= 62", cyc);
        end
        tick();
        ones = 0;
        for (int i = 0; i < 16; i++) begin
            tick();
            ones += int'(led_out) + int'(!led_out_n);
        end
        n_checks++;
        if (ones !== 32 || duty !== 4'd15 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL full_on: lit=%0d duty=%0d busy=%b, expected 32/15/0", ones, duty, busy);
        end
    endtask

    task automatic test_reversal();
        int lit;
        do_reset();
        led_req = 1'b1;
        for (int i = 0; i < 40 && duty !== 4'd7; i++) tick();
        n_checks++;
        if (duty !== 4'd7) begin
            n_fail++;
            $display("FAIL reversal_reach7: duty=%0d, expected 7", duty);
        end
        led_req = 1'b0;
        tick();
        n_checks++;
        if (duty !== 4'd7 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL reversal_no_jump: duty=%0d busy=%b, expected 7/1", duty, busy);
        end
        for (int i = 0; i < 4 && duty === 4'd7; i++) tick();
        n_checks++;
        if (duty !== 4'd6) begin
            n_fail++;
            $display("FAIL reversal_first_down: duty=%0d, expected 6", duty);
        end
        for (int k = 5; k >= 0; k--) begin
            repeat (4) tick();
            n_checks++;
            if (duty !== 4'(k) || busy !== (k != 0)) begin
                n_fail++;
                $display("FAIL reversal_step: duty=%0d busy=%b, expected %0d/%b", duty, busy, k, (k != 0));
            end
        end
        tick();
        lit = 0;
        for (int i = 0; i < 16; i++) begin
            tick();
            lit += int'(led_out) + int'(busy) + int'(duty != 4'd0);
        end
        n_checks++;
        if (lit !== 0) begin
            n_fail++;
            $display("FAIL reversal_off: %0d nonzero samples of led_out/busy/duty, expected 0", lit);
        end
    endtask

    task automatic test_pwm();
        int ones;
        int zeros_n;
        do_reset();
        led_req = 1'b1;
        for (int i = 0; i < 30 && duty !== 4'd5; i++) tick();
        n_checks++;
        if (duty !== 4'd5) begin
            n_fail++;
            $display("FAIL pwm_reach5: duty=%0d, expected 5", duty);
        end
        // Reversing direction every clock freezes duty at 5 while staying in the ramp states.
        ones = 0;
        zeros_n = 0;
        for (int i = 0; i <= 16; i++) begin
            led_req = ~led_req;
            tick();
            if (i > 0) begin
                ones    += int'(led_out);
                zeros_n += int'(!led_out_n);
            end
        end
        n_checks++;
        if (ones !== 5 || duty !== 4'd5 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL pwm_duty5: high=%0d/16 duty=%0d busy=%b, expected 5/5/1", ones, duty, busy);
        end
        n_checks++;
        if (zeros_n !== 5) begin
            n_fail++;
            $display("FAIL pwm_duty5_n: low=%0d/16, expected 5", zeros_n);
        end
    endtask

    task automatic test_bypass();
        logic [3:0] exp_duty;
        fade_en = 1'b0;
        for (int i = 0; i < 4; i++) begin
            led_req  = (i % 2 == 0);
            exp_duty = (i % 2 == 0) ? 4'd15 : 4'd0;
            tick();
            n_checks++;
            if (duty !== exp_duty || busy !== 1'b0) begin
                n_fail++;
                $display("FAIL bypass_toggle: duty=%0d busy=%b, expected %0d/0", duty, busy, exp_duty);
            end
        end
        led_req = 1'b1;
        tick();
        fade_en = 1'b1;
        repeat (3) tick();
        n_checks++;
        if (duty !== 4'd15 || busy !== 1'b0 || led_out !== 1'b1) begin
            n_fail++;
            $display("FAIL bypass_resume: duty=%0d busy=%b led_out=%b, expected 15/0/1", duty, busy, led_out);
        end
    endtask

    task automatic test_reset_mid_op();
        do_reset();
        led_req = 1'b1;
        for (int i = 0; i < 50 && duty_n !== 4'd9; i++) tick();
        n_checks++;
        if (duty_n !== 4'd9 || duty !== 4'd9) begin
            n_fail++;
            $display("FAIL midop_reach9: duty_n=%0d duty=%0d, expected 9/9", duty_n, duty);
        end
        sys_rst = 1'b1;
        #1;
        n_checks++;
        if (led_out_n !== 1'b1 || duty_n !== 4'd0 || busy_n !== 1'b0) begin
            n_fail++;
            $display("FAIL midop_reset_n: led_out=%b duty=%0d busy=%b, expected 1/0/0", led_out_n, duty_n, busy_n);
        end
        n_checks++;
        if (led_out !== 1'b0 || duty !== 4'd0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL midop_reset: led_out=%b duty=%0d busy=%b, expected 0/0/0", led_out, duty, busy);
        end
        tick();
        tick();
        sys_rst = 1'b0;
        tick();
        n_checks++;
        if (duty_n !== 4'd0 || busy_n !== 1'b1 || led_out_n !== 1'b1) begin
            n_fail++;
            $display("FAIL midop_restart: duty=%0d busy=%b led_out=%b, expected 0/1/1", duty_n, busy_n, led_out_n);
        end
        for (int i = 0; i < 5 && duty_n === 4'd0; i++) tick();
        n_checks++;
        if (duty_n !== 4'd1) begin
            n_fail++;
            $display("FAIL midop_first_step: duty=%0d, expected 1", duty_n);
        end
    endtask

    initial begin
        test_reset();
        test_ramp_up();
        test_reversal();
        test_pwm();
        test_bypass();
        test_reset_mid_op();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
